// File: rtl/rv_isa_pkg.sv
// Shared RV32 ISA constants: major opcodes (inst[6:2]) and immediate format codes.
package rv_isa_pkg;

    // Major opcode field inst[6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    // Immediate format codes as presented on out_fmt
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_NONE = 3'd7
    } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: classifies the format and builds the extended immediate.
module imm_decode
    import rv_isa_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]      inst_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o
);

    logic signed [31:0] imm32;
    fmt_e               fmt;

    // Every legal immediate fits a signed 32-bit value (Z is small and positive),
    // so one sign-extension to XLEN covers both RV32 and RV64.
    always_comb begin
        imm32     = '0;
        fmt       = FMT_NONE;
        illegal_o = 1'b1;
        if (inst_i[1:0] == 2'b11) begin
            illegal_o = 1'b0;
            case (inst_i[6:2])
                OPC_OP: begin
                    fmt = FMT_R;
                end
                OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                    fmt   = FMT_I;
                    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                end
                OPC_STORE: begin
                    fmt   = FMT_S;
                    imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
                end
                OPC_BRANCH: begin
                    fmt   = FMT_B;
                    imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                             inst_i[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt   = FMT_U;
                    imm32 = {inst_i[31:12], 12'b0};
                end
                OPC_JAL: begin
                    fmt   = FMT_J;
                    imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                             inst_i[30:21], 1'b0};
                end
                OPC_SYSTEM: begin
                    if (inst_i[14]) begin
                        fmt   = FMT_Z;
                        imm32 = {27'b0, inst_i[19:15]};
                    end else begin
                        fmt   = FMT_I;
                        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                    end
                end
                default: begin
                    fmt       = FMT_NONE;
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

    assign imm_o = XLEN'(imm32);
    assign fmt_o = fmt;

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decode, then a 2-entry FIFO with valid/ready handshakes.
module imm_gen_stage
    import rv_isa_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_illegal;

    logic [XLEN-1:0]  imm_mem [2];
    logic [2:0]       fmt_mem [2];
    logic             ill_mem [2];
    logic [TAG_W-1:0] tag_mem [2];

    logic [1:0] count_q, count_d;
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    logic       in_ready_q;
    logic       push, pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst_i    (in_inst),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready_q && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Next-state for occupancy and pointers; flush overrides any push/pop
    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (flush) begin
            count_d = '0;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
        end else begin
            if (push) wptr_d = ~wptr_q;
            if (pop)  rptr_d = ~rptr_q;
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    // Control state register; in_ready is registered from next-cycle occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            in_ready_q <= (count_d < 2'd2);
        end
    end

    // Decoded-result storage; data needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            imm_mem[wptr_q] <= dec_imm;
            fmt_mem[wptr_q] <= dec_fmt;
            ill_mem[wptr_q] <= dec_illegal;
            tag_mem[wptr_q] <= in_tag;
        end
    end

    // Head-of-FIFO outputs, forced to zero while nothing is valid
    always_comb begin
        out_imm     = '0;
        out_fmt     = '0;
        out_illegal = 1'b0;
        out_tag     = '0;
        if (out_valid) begin
            out_imm     = imm_mem[rptr_q];
            out_fmt     = fmt_mem[rptr_q];
            out_illegal = ill_mem[rptr_q];
            out_tag     = tag_mem[rptr_q];
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_stage;

    localparam int TAG_W = 5;

    typedef struct {
        logic [63:0]      imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, out_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;

    logic             in_ready_a, out_valid_a, out_ill_a;
    logic [31:0]      out_imm_a;
    logic [2:0]       out_fmt_a;
    logic [TAG_W-1:0] out_tag_a;

    logic             in_ready_b, out_valid_b, out_ill_b;
    logic [63:0]      out_imm_b;
    logic [2:0]       out_fmt_b;
    logic [TAG_W-1:0] out_tag_b;

    exp_t q[$];
    exp_t cur_exp;
    int   vectors = 0;
    int   miscompares = 0;
    bit   armed = 1'b0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
        .out_fmt(out_fmt_a), .out_illegal(out_ill_a), .out_tag(out_tag_a)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
        .out_fmt(out_fmt_b), .out_illegal(out_ill_b), .out_tag(out_tag_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: immediates assembled arithmetically from the ISA field rules (RV64 view)
    function automatic exp_t model(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
        exp_t   e;
        longint s;
        s     = longint'($signed(inst));
        e.imm = 64'd0;
        e.fmt = 3'd7;
        e.ill = 1'b1;
        e.tag = tag;
        if (inst[1:0] == 2'b11) begin
            e.ill = 1'b0;
            case (inst[6:2])
                5'h0C: e.fmt = 3'd0;
                5'h04, 5'h00, 5'h19: begin e.fmt = 3'd1; e.imm = s >>> 20; end
                5'h08: begin
                    e.fmt = 3'd2;
                    e.imm = ((s >>> 25) << 5) + longint'(inst[11:7]);
                end
                5'h18: begin
                    e.fmt = 3'd3;
                    e.imm = ((s >>> 31) << 12) + (longint'(inst[7]) << 11)
                          + (longint'(inst[30:25]) << 5) + (longint'(inst[11:8]) << 1);
                end
                5'h0D, 5'h05: begin e.fmt = 3'd4; e.imm = (s >>> 12) << 12; end
                5'h1B: begin
                    e.fmt = 3'd5;
                    e.imm = ((s >>> 31) << 20) + (longint'(inst[19:12]) << 12)
                          + (longint'(inst[20]) << 11) + (longint'(inst[30:21]) << 1);
                end
                5'h1C: begin
                    if (inst[14]) begin e.fmt = 3'd6; e.imm = longint'(inst[19:15]); end
                    else begin e.fmt = 3'd1; e.imm = s >>> 20; end
                end
                default: begin e.fmt = 3'd7; e.ill = 1'b1; end
            endcase
        end
        return e;
    endfunction

    // Monitor: compares both instances against the scoreboard head every negedge
    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready32", {63'd0, in_ready_a}, {63'd0, q.size() < 2});
            chk("in_ready64", {63'd0, in_ready_b}, {63'd0, q.size() < 2});
            chk("out_valid32", {63'd0, out_valid_a}, {63'd0, q.size() != 0});
            chk("out_valid64", {63'd0, out_valid_b}, {63'd0, q.size() != 0});
            if (q.size() != 0) begin
                chk("imm32", {32'd0, out_imm_a}, {32'd0, q[0].imm[31:0]});
                chk("imm64", out_imm_b, q[0].imm);
                chk("fmt32", {61'd0, out_fmt_a}, {61'd0, q[0].fmt});
                chk("fmt64", {61'd0, out_fmt_b}, {61'd0, q[0].fmt});
                chk("illegal32", {63'd0, out_ill_a}, {63'd0, q[0].ill});
                chk("illegal64", {63'd0, out_ill_b}, {63'd0, q[0].ill});
                chk("tag32", {59'd0, out_tag_a}, {59'd0, q[0].tag});
                chk("tag64", {59'd0, out_tag_b}, {59'd0, q[0].tag});
                if (out_ready && !flush && rst_n) void'(q.pop_front());
            end else begin
                chk("idle_fields32", {27'd0, out_imm_a, out_fmt_a, out_ill_a, out_tag_a}, 64'd0);
                chk("idle_fields64", {55'd0, out_fmt_b, out_ill_b, out_tag_b} | out_imm_b, 64'd0);
            end
        end
    end

    // One clock: decide acceptance at negedge, commit to scoreboard at posedge
    task automatic tick(output bit acc);
        bit clr;
        @(negedge clk);
        acc = in_valid && in_ready_a && !flush && rst_n;
        clr = flush || !rst_n;
        @(posedge clk);
        if (clr) q.delete();
        else if (acc) q.push_back(cur_exp);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_tag   = tag;
        cur_exp  = model(inst, tag);
        for (int i = 0; i < 50 && !acc; i++) tick(acc);
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick(acc);
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    logic [4:0] ops [10] = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h0C,
                             5'h0D, 5'h18, 5'h19, 5'h1B, 5'h1C};

    initial begin
        bit acc;
        logic [31:0] r;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_tag = '0;
        cur_exp = model(32'd0, '0);
        @(posedge clk); #1;
        armed = 1'b1;
        tick(acc);
        rst_n = 1'b1;
        idle(2);

        // Directed decode vectors, back to back
        send(32'hFFF00093, 5'd1);
        send(32'hFE000EE3, 5'd2);
        send(32'h800000B7, 5'd3);
        send(32'h300FD073, 5'd4);
        send(32'h0000007F, 5'd5);
        send(32'h00000090, 5'd6);
        idle(4);

        // Backpressure: third entry must stay upstream
        out_ready = 1'b0;
        send(32'h00A00093, 5'd1);
        send(32'h00B00093, 5'd2);
        chk("full_in_ready", {63'd0, in_ready_a}, 64'd0);
        in_valid = 1'b1; in_inst = 32'h00C00093; in_tag = 5'd3;
        cur_exp = model(in_inst, in_tag);
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            chk("tag3_held", {63'd0, acc}, 64'd0);
        end
        out_ready = 1'b1;
        send(32'h00C00093, 5'd3);
        drain();

        // Flush while full with a same-cycle input
        out_ready = 1'b0;
        send(32'h12345037, 5'd7);
        send(32'h0080006F, 5'd8);
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 5'd9;
        cur_exp = model(in_inst, in_tag);
        flush = 1'b1;
        tick(acc);
        flush = 1'b0; in_valid = 1'b0;
        idle(2);
        out_ready = 1'b1;
        idle(2);

        // Reset while full
        out_ready = 1'b0;
        send(32'h00112023, 5'd10);
        send(32'h00002003, 5'd11);
        rst_n = 1'b0;
        tick(acc);
        rst_n = 1'b1;
        idle(2);
        out_ready = 1'b1;

        // Randomised traffic with occasional flush
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            if ($urandom_range(0, 11) < 10) r[6:2] = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) != 0) r[1:0] = 2'b11;
            in_inst   = r;
            in_tag    = TAG_W'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 31) == 0);
            cur_exp   = model(in_inst, in_tag);
            tick(acc);
        end
        drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  discard all buffered entries and any same-cycle input.
REQ-006 SHALL have port in_valid  input  1  upstream holds a valid instruction.
REQ-007 SHALL have port in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 SHALL have port in_inst  input  32  raw RV32 instruction word.
REQ-009 SHALL have port in_tag  input  TAG_W  opaque sideband, passed through unchanged.
REQ-010 SHALL have port out_valid  output  1  out_* fields hold a valid result.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-012 SHALL have port out_imm  output  XLEN  extended immediate.
REQ-013 SHALL have port out_fmt  output  3  format code (R=0, I=1, S=2, B=3, U=4, J=5, Z=6, NONE=7).
REQ-014 SHALL have port out_illegal  output  1  unrecognised opcode or inst[1:0] != 2'b11.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the current result.

Function
REQ-016 Decode SHALL use inst[6:2]: OP -> R, imm 0; OP_IMM/LOAD/JALR -> I; STORE -> S; BRANCH -> B; LUI/AUIPC -> U; JAL -> J; SYSTEM with funct3[2]=1 -> Z; SYSTEM with funct3[2]=0 -> I.
REQ-017 I/S/B/J immediates SHALL be sign-extended from inst[31] to XLEN; B and J SHALL have bit 0 = 0.
REQ-018 U immediate SHALL be {inst[31:12], 12'b0} sign-extended to XLEN (RV64 semantics when XLEN=64).
REQ-019 Z immediate SHALL be inst[19:15] zero-extended to XLEN.
REQ-020 Any other opcode, or inst[1:0] != 2'b11, SHALL give out_fmt=NONE, out_imm=0, out_illegal=1; no default to J.
REQ-021 A transfer SHALL occur on an edge where valid && ready on that side.
REQ-022 Storage SHALL be a 2-entry FIFO of decoded results; in_ready SHALL be registered and equal to (count < 2).
REQ-023 Latency SHALL be 1 cycle: a result accepted at edge N SHALL show out_valid at N+1 at the earliest.
REQ-024 Sustained throughput SHALL be 1 per cycle while out_ready=1.
REQ-025 Results SHALL leave in acceptance order; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; push when full SHALL NOT occur because in_ready=0.
REQ-027 Read and write pointers SHALL be 1 bit each and wrap modulo 2.
REQ-028 flush=1 SHALL set count to 0 at the next edge and SHALL drop any same-cycle push and pop; flush SHALL take priority over every other event.
REQ-029 When out_valid=0, out_imm/out_fmt/out_illegal/out_tag SHALL read 0.

Reset
REQ-030 rst_n=0 at an edge SHALL clear count and pointers, giving out_valid=0, in_ready=1 and all out_* = 0 on the next cycle.
REQ-031 Reset mid-transfer SHALL discard all entries; reset SHALL take priority over flush.
REQ-032 FIFO data storage SHALL need no reset; only control state is reset.

Structure
REQ-033 Opcode constants and format codes SHALL be defined in the shared package rv_isa_pkg.
REQ-034 Decode SHALL be a combinational sub-module imm_decode (inst in; imm, fmt, illegal out) instantiated before the FIFO.

Verification
REQ-035 XLEN=32, push 0xFFF00093 (addi -1) -> out_imm=0xFFFFFFFF, fmt=I, illegal=0, one cycle later.
REQ-036 Push 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, fmt=B; XLEN=64, push 0x800000B7 (lui) -> imm 0xFFFFFFFF80000000, fmt=U.
REQ-037 Push 0x300FD073 (csrrwi, zimm 31) -> imm 0x1F, fmt=Z; push 0x0000007F -> fmt=NONE, imm 0, illegal=1.
REQ-038 out_ready=0, push tags 1,2,3 back-to-back -> in_ready=0 after the 2nd accept; tag 3 held upstream; release yields 1,2,3 in order.
REQ-039 FIFO full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed input never appears.
REQ-040 rst_n=0 while full with out_ready=0 -> next cycle out_valid=0, in_ready=1, out_* = 0.
